// File: rtl/throw_pkg.sv
// Shared types and constants for the projectile controller.
package throw_pkg;

    // Controller phases: waiting, charging power, ballistic flight, one-cycle wrap-up.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        FLIGHT = 2'd2,
        DONE   = 2'd3
    } throw_state_e;

    localparam int SCREEN_W  = 1024;
    localparam int SCREEN_H  = 768;
    localparam int POWER_MAX = 63;

    localparam int POWER_W = 6;   // charge level
    localparam int POS_W   = 13;  // signed internal position
    localparam int OUT_W   = 12;  // unsigned pixel output
    localparam int VX_W    = 4;   // unsigned horizontal speed
    localparam int VY_W    = 8;   // signed vertical speed

    // Clamp a signed internal coordinate into 0..hi for the renderer.
    function automatic logic [OUT_W-1:0] clamp_pos(input logic signed [POS_W-1:0] v,
                                                   input logic [OUT_W-1:0]        hi);
        logic [OUT_W-1:0] r;
        if (v[POS_W-1]) begin
            r = '0;
        end else if (v[POS_W-2:0] > hi) begin
            r = hi;
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/throw_step.sv
// One physics step: advance position by velocity, apply gravity, classify the new point.
module throw_step
    import throw_pkg::*;
#(
    parameter int START_Y  = 600,
    parameter int TARGET_X = 850,
    parameter int TARGET_Y = 560,
    parameter int TARGET_W = 64,
    parameter int TARGET_H = 64,
    parameter int GRAVITY  = 1
) (
    input  logic signed [POS_W-1:0] x_i,
    input  logic signed [POS_W-1:0] y_i,
    input  logic        [VX_W-1:0]  vx_i,
    input  logic signed [VY_W-1:0]  vy_i,
    input  logic                    dir_i,   // 1: move toward +x
    output logic signed [POS_W-1:0] x_o,
    output logic signed [POS_W-1:0] y_o,
    output logic signed [VY_W-1:0]  vy_o,
    output logic                    hit_det,
    output logic                    end_det
);

    localparam logic signed [POS_W-1:0] TX_LO  = POS_W'(TARGET_X);
    localparam logic signed [POS_W-1:0] TX_HI  = POS_W'(TARGET_X + TARGET_W);
    localparam logic signed [POS_W-1:0] TY_LO  = POS_W'(TARGET_Y);
    localparam logic signed [POS_W-1:0] TY_HI  = POS_W'(TARGET_Y + TARGET_H);
    localparam logic signed [POS_W-1:0] GROUND = POS_W'(START_Y);
    localparam logic signed [POS_W-1:0] X_LIM  = POS_W'(SCREEN_W);
    localparam logic signed [POS_W-1:0] GRAV   = POS_W'(GRAVITY);
    localparam logic signed [POS_W-1:0] VY_MAX = POS_W'(127);

    logic signed [POS_W-1:0] vx_ext;
    logic signed [POS_W-1:0] vy_ext;
    logic signed [POS_W-1:0] vy_sum;

    // Ground test uses the post-gravity vy, so a throw with zero power lands after one frame.
    always_comb begin
        vx_ext = {{(POS_W-VX_W){1'b0}}, vx_i};
        vy_ext = {{(POS_W-VY_W){vy_i[VY_W-1]}}, vy_i};
        x_o    = dir_i ? (x_i + vx_ext) : (x_i - vx_ext);
        y_o    = y_i + vy_ext;
        vy_sum = vy_ext + GRAV;
        if (vy_sum > VY_MAX) begin
            vy_o = VY_MAX[VY_W-1:0];
        end else begin
            vy_o = vy_sum[VY_W-1:0];
        end
        hit_det = (x_o >= TX_LO) && (x_o < TX_HI) && (y_o >= TY_LO) && (y_o < TY_HI);
        end_det = ((y_o >= GROUND) && (vy_o > 8'sd0)) || x_o[POS_W-1] || (x_o >= X_LIM);
    end

endmodule

// File: rtl/throw_ctl.sv
// Local-player throw controller: power charge on fire hold, gravity flight, hit pulse.
// Handshake: none; frame_tick is a one-cycle strobe, outputs are plain registered levels/pulses.
module throw_ctl
    import throw_pkg::*;
#(
    parameter logic PLAYER   = 1'b1,
    parameter int   START_X  = 100,
    parameter int   START_Y  = 600,
    parameter int   TARGET_X = 850,
    parameter int   TARGET_Y = 560,
    parameter int   TARGET_W = 64,
    parameter int   TARGET_H = 64,
    parameter int   GRAVITY  = 1
) (
    input  logic              clk60MHz,
    input  logic              rst_n,
    input  logic [2:0]        turn,
    input  logic              frame_tick,
    input  logic              fire,
    output logic              throw_flag,
    output logic [OUT_W-1:0]  proj_x,
    output logic [OUT_W-1:0]  proj_y,
    output logic [POWER_W-1:0] power,
    output logic              hit
);

    localparam logic signed [POS_W-1:0] X0    = POS_W'(START_X);
    localparam logic signed [POS_W-1:0] Y0    = POS_W'(START_Y);
    localparam logic [OUT_W-1:0]        PX0   = OUT_W'(START_X);
    localparam logic [OUT_W-1:0]        PY0   = OUT_W'(START_Y);
    localparam logic [OUT_W-1:0]        X_MAX = OUT_W'(SCREEN_W - 1);
    localparam logic [OUT_W-1:0]        Y_MAX = OUT_W'(SCREEN_H - 1);
    localparam logic [POWER_W-1:0]      P_MAX = POWER_W'(POWER_MAX);

    throw_state_e             state_q, state_d;
    logic                     fire_q, fire_d;
    logic [POWER_W-1:0]       power_q, power_d;
    logic signed [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic [VX_W-1:0]          vx_q, vx_d;
    logic signed [VY_W-1:0]   vy_q, vy_d;
    logic                     throw_flag_q, throw_flag_d;
    logic                     hit_q, hit_d;
    logic [OUT_W-1:0]         proj_x_q, proj_x_d, proj_y_q, proj_y_d;

    logic                     my_turn;
    logic                     fire_rise;
    logic signed [POS_W-1:0]  nx, ny;
    logic signed [VY_W-1:0]   nvy;
    logic                     hit_det, end_det;
    logic                     unused_turn;

    assign my_turn     = (turn[0] == PLAYER);
    assign fire_rise   = fire & ~fire_q;
    assign unused_turn = ^turn[2:1];

    throw_step #(
        .START_Y (START_Y),
        .TARGET_X(TARGET_X),
        .TARGET_Y(TARGET_Y),
        .TARGET_W(TARGET_W),
        .TARGET_H(TARGET_H),
        .GRAVITY (GRAVITY)
    ) u_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .vx_i   (vx_q),
        .vy_i   (vy_q),
        .dir_i  (PLAYER),
        .x_o    (nx),
        .y_o    (ny),
        .vy_o   (nvy),
        .hit_det(hit_det),
        .end_det(end_det)
    );

    // Next-state and registered-output decode; release beats a same-cycle frame_tick.
    always_comb begin
        state_d      = state_q;
        fire_d       = fire;
        power_d      = power_q;
        x_d          = x_q;
        y_d          = y_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        throw_flag_d = 1'b0;
        hit_d        = 1'b0;
        proj_x_d     = proj_x_q;
        proj_y_d     = proj_y_q;
        case (state_q)
            IDLE: begin
                proj_x_d = PX0;
                proj_y_d = PY0;
                if (fire_rise && my_turn) begin
                    state_d = CHARGE;
                    power_d = '0;
                end
            end
            CHARGE: begin
                if (!my_turn) begin
                    state_d = IDLE;
                    power_d = '0;
                end else if (!fire) begin
                    state_d      = FLIGHT;
                    throw_flag_d = 1'b1;
                    x_d          = X0;
                    y_d          = Y0;
                    vx_d         = power_q[POWER_W-1:2];
                    vy_d         = -$signed({{(VY_W-POWER_W+1){1'b0}}, power_q[POWER_W-1:1]});
                end else if (frame_tick && (power_q != P_MAX)) begin
                    power_d = power_q + POWER_W'(1);
                end
            end
            FLIGHT: begin
                throw_flag_d = 1'b1;
                if (frame_tick) begin
                    x_d      = nx;
                    y_d      = ny;
                    vy_d     = nvy;
                    proj_x_d = clamp_pos(nx, X_MAX);
                    proj_y_d = clamp_pos(ny, Y_MAX);
                    if (hit_det) begin
                        state_d      = DONE;
                        hit_d        = 1'b1;
                        throw_flag_d = 1'b0;
                    end else if (end_det) begin
                        state_d      = DONE;
                        throw_flag_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                power_d  = '0;
                proj_x_d = PX0;
                proj_y_d = PY0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk60MHz) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fire_q       <= 1'b0;
            power_q      <= '0;
            x_q          <= X0;
            y_q          <= Y0;
            vx_q         <= '0;
            vy_q         <= '0;
            throw_flag_q <= 1'b0;
            hit_q        <= 1'b0;
            proj_x_q     <= PX0;
            proj_y_q     <= PY0;
        end else begin
            state_q      <= state_d;
            fire_q       <= fire_d;
            power_q      <= power_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            throw_flag_q <= throw_flag_d;
            hit_q        <= hit_d;
            proj_x_q     <= proj_x_d;
            proj_y_q     <= proj_y_d;
        end
    end

    assign throw_flag = throw_flag_q;
    assign hit        = hit_q;
    assign proj_x     = proj_x_q;
    assign proj_y     = proj_y_q;
    assign power      = power_q;

endmodule
